// File: rtl/dram_sequencer_pkg.sv
// Shared definitions for the VG8020 DRAM strobe sequencer: state encoding,
// idle strobe levels and the state-to-strobe decode.
package dram_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RAS     = 3'd1,
        ST_MUX     = 3'd2,
        ST_CAS     = 3'd3,
        ST_REFRESH = 3'd4,
        ST_PRE     = 3'd5
    } state_t;

    typedef struct packed {
        logic ras_n;
        logic cas_n;
        logic we_n;
        logic mux;
        logic busy;
    } strobes_t;

    localparam strobes_t IDLE_STROBES = '{ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1, mux: 1'b0, busy: 1'b0};

    // we_n only follows the write flag while the column address is on the bus.
    function automatic strobes_t decode_strobes(input state_t s, input logic wr);
        strobes_t o;
        o      = IDLE_STROBES;
        o.busy = (s != ST_IDLE);
        case (s)
            ST_RAS: begin
                o.ras_n = 1'b0;
            end
            ST_MUX: begin
                o.ras_n = 1'b0;
                o.mux   = 1'b1;
                o.we_n  = ~wr;
            end
            ST_CAS: begin
                o.ras_n = 1'b0;
                o.cas_n = 1'b0;
                o.mux   = 1'b1;
                o.we_n  = ~wr;
            end
            ST_REFRESH: begin
                o.ras_n = 1'b0;
            end
            default: begin
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dram_sequencer_rowcol_selector.sv
// Row/column address multiplexer for the 8-bit DRAM address bus.
module rowcol_selector (
    input  logic [15:0] addr,
    input  logic        mux,
    output logic [7:0]  dram_addr
);

    assign dram_addr = mux ? addr[15:8] : addr[7:0];

endmodule

// File: rtl/dram_sequencer.sv
// DRAM strobe sequencer (RAS_n, MUX, CAS_n, WE_n) driven from the Z80 bus cycle.
// Define DRAM_REFRESH_EN to build the RAS-only REFRESH state.
module dram_sequencer
    import dram_sequencer_pkg::*;
#(
    parameter int RAS_TO_MUX = 1,
    parameter int MUX_TO_CAS = 1,
    parameter int PRECHARGE  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mreq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic        ram_sel,
    input  logic [15:0] addr,
    output logic [7:0]  dram_addr,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic        mux,
    output logic        busy
);

    state_t     state;
    state_t     next_state;
    logic [1:0] phase;
    logic [1:0] next_phase;
    logic       wr_flag;
    logic       next_wr_flag;
    strobes_t   strobes;
    strobes_t   next_strobes;

    // Phase counter is loaded with (duration - 1) and counts down to zero.
    function automatic logic [1:0] phase_load(input state_t s);
        case (s)
            ST_RAS:  return 2'(RAS_TO_MUX - 1);
            ST_MUX:  return 2'(MUX_TO_CAS - 1);
            ST_PRE:  return 2'(PRECHARGE - 1);
            default: return 2'd0;
        endcase
    endfunction

    always_comb begin
        next_state   = state;
        next_wr_flag = wr_flag;
        case (state)
            ST_IDLE: begin
                if (!mreq_n) begin
                    if (!rfsh_n) begin
`ifdef DRAM_REFRESH_EN
                        next_state = ST_REFRESH;
`endif
                    end else if (ram_sel && (!rd_n || !wr_n)) begin
                        next_state   = ST_RAS;
                        next_wr_flag = !wr_n;
                    end
                end
            end
            ST_RAS: begin
                if (mreq_n)
                    next_state = ST_PRE;
                else if (phase == 2'd0)
                    next_state = ST_MUX;
            end
            ST_MUX: begin
                if (mreq_n)
                    next_state = ST_PRE;
                else if (phase == 2'd0)
                    next_state = ST_CAS;
            end
            ST_CAS: begin
                if (mreq_n)
                    next_state = ST_PRE;
            end
`ifdef DRAM_REFRESH_EN
            ST_REFRESH: begin
                if (mreq_n)
                    next_state = ST_PRE;
            end
`endif
            ST_PRE: begin
                if (phase == 2'd0)
                    next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        next_phase = (phase != 2'd0) ? phase - 2'd1 : phase;
        if (next_state != state)
            next_phase = phase_load(next_state);

        // Strobes are decoded from the next state so they leave the register with it.
        next_strobes = decode_strobes(next_state, next_wr_flag);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            phase   <= 2'd0;
            wr_flag <= 1'b0;
            strobes <= IDLE_STROBES;
        end else begin
            state   <= next_state;
            phase   <= next_phase;
            wr_flag <= next_wr_flag;
            strobes <= next_strobes;
        end
    end

    assign ras_n = strobes.ras_n;
    assign cas_n = strobes.cas_n;
    assign we_n  = strobes.we_n;
    assign mux   = strobes.mux;
    assign busy  = strobes.busy;

    rowcol_selector u_rowcol_selector (
        .addr      (addr),
        .mux       (mux),
        .dram_addr (dram_addr)
    );

endmodule

// File: tb/tb_dram_sequencer.sv
// Scoreboard bench for dram_sequencer: bus-cycle timelines are turned into per-cycle
// expected strobes and checked by an independent monitor. Honours DRAM_REFRESH_EN.
module tb_dram_sequencer;

    localparam int R = 1;
    localparam int M = 1;
    localparam int P = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mreq_n, rd_n, wr_n, rfsh_n, ram_sel;
    logic [15:0] addr;
    logic [7:0]  dram_addr;
    logic        ras_n, cas_n, we_n, mux, busy;

    int checks = 0;
    int errors = 0;

    typedef enum {K_READ, K_WRITE, K_REFRESH, K_IGNORED, K_RESET} kind_e;
    typedef enum {PH_IDLE, PH_ROW, PH_COL, PH_STROBE, PH_REF, PH_PRE} phase_e;

    typedef struct {
        logic       ras_n;
        logic       cas_n;
        logic       we_n;
        logic       mux;
        logic       busy;
        logic [7:0] dram_addr;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    dram_sequencer #(
        .RAS_TO_MUX (R),
        .MUX_TO_CAS (M),
        .PRECHARGE  (P)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mreq_n    (mreq_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .rfsh_n    (rfsh_n),
        .ram_sel   (ram_sel),
        .addr      (addr),
        .dram_addr (dram_addr),
        .ras_n     (ras_n),
        .cas_n     (cas_n),
        .we_n      (we_n),
        .mux       (mux),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t expected_outputs(input phase_e ph, input logic wr, input logic [15:0] a, input string tag);
        exp_t e;
        e.ras_n = 1'b1; e.cas_n = 1'b1; e.we_n = 1'b1; e.mux = 1'b0; e.busy = 1'b0;
        e.dram_addr = a[7:0];
        e.tag = tag;
        case (ph)
            PH_ROW:    begin e.ras_n = 1'b0; e.busy = 1'b1; end
            PH_COL:    begin e.ras_n = 1'b0; e.mux = 1'b1; e.we_n = ~wr; e.busy = 1'b1; e.dram_addr = a[15:8]; end
            PH_STROBE: begin e.ras_n = 1'b0; e.cas_n = 1'b0; e.mux = 1'b1; e.we_n = ~wr; e.busy = 1'b1; e.dram_addr = a[15:8]; end
            PH_REF:    begin e.ras_n = 1'b0; e.busy = 1'b1; end
            PH_PRE:    begin e.busy = 1'b1; end
            default:   begin end
        endcase
        return e;
    endfunction

    // Bus phase j cycles after acceptance of an access: row for R, column for M, then strobed.
    function automatic phase_e access_phase(input int j);
        if (j < R)     return PH_ROW;
        if (j < R + M) return PH_COL;
        return PH_STROBE;
    endfunction

    task automatic drive_slot(input logic rst, input logic m, input logic rd, input logic wr,
                              input logic rf, input logic sel, input logic [15:0] a, input exp_t e);
        reset = rst; mreq_n = m; rd_n = rd; wr_n = wr; rfsh_n = rf; ram_sel = sel; addr = a;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One bus transaction: mreq_n low for h cycles starting at slot 0, then released until idle.
    task automatic applyStimulus(input kind_e kind, input logic [15:0] a, input int h,
                                 input bit b2b, input bit skip_first, input int variant, input string tag);
        bit   active;
        logic wr;
        int   len;
        logic m, rd, wrn, rf, sel, rst;
        phase_e ph;
        active = (kind == K_READ) || (kind == K_WRITE) || (kind == K_RESET);
`ifdef DRAM_REFRESH_EN
        if (kind == K_REFRESH) active = 1'b1;
`endif
        wr  = (kind == K_WRITE) || (kind == K_RESET && variant[0]);
        len = (kind == K_RESET) ? h + 2 : h + P + 2;
        for (int k = (skip_first ? 1 : 0); k < len; k++) begin
            m = 1'b1; rd = 1'b1; wrn = 1'b1; rf = 1'b1; sel = 1'b1; rst = 1'b0;
            if (k < h || (b2b && k > h)) begin
                m = 1'b0;
                case (kind)
                    K_READ:    rd = 1'b0;
                    K_WRITE:   wrn = 1'b0;
                    K_RESET:   begin if (variant[0]) wrn = 1'b0; else rd = 1'b0; end
                    K_REFRESH: begin rf = 1'b0; rd = variant[0] ? 1'b0 : 1'b1; end
                    default: begin
                        if (variant == 0)      begin sel = 1'b0; rd = 1'b0; end
                        else if (variant == 1) begin sel = 1'b0; wrn = 1'b0; end
                    end
                endcase
            end
            if (kind == K_RESET && k == h - 1) rst = 1'b1;
            ph = PH_IDLE;
            if (k > 0 && active) begin
                if (kind == K_RESET)
                    ph = (k - 1 < h - 1) ? access_phase(k - 1) : PH_IDLE;
                else if (k - 1 < h)
                    ph = (kind == K_REFRESH) ? PH_REF : access_phase(k - 1);
                else if (k - 1 < h + P)
                    ph = PH_PRE;
            end
            drive_slot(rst, m, rd, wrn, rf, sel, a, expected_outputs(ph, wr, a, $sformatf("%s_k%0d", tag, k)));
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (ras_n !== e.ras_n || cas_n !== e.cas_n || we_n !== e.we_n || mux !== e.mux ||
            busy !== e.busy || dram_addr !== e.dram_addr) begin
            errors++;
            $display("[TB] FAIL %s: got ras_n=%b cas_n=%b we_n=%b mux=%b busy=%b dram_addr=%h, expected ras_n=%b cas_n=%b we_n=%b mux=%b busy=%b dram_addr=%h",
                     e.tag, ras_n, cas_n, we_n, mux, busy, dram_addr,
                     e.ras_n, e.cas_n, e.we_n, e.mux, e.busy, e.dram_addr);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        kind_e       kind;
        logic [15:0] a;
        int          h;
        int          variant;
        bit          b2b;
        bit          carry;
        kind_e       carry_kind;
        logic [15:0] carry_addr;

        reset = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1; ram_sel = 1'b0; addr = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        drive_slot(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h3C21, expected_outputs(PH_IDLE, 1'b0, 16'h3C21, "reset_state"));

        applyStimulus(K_READ,    16'h0F5A, 3, 0, 0, 0, "read");
        applyStimulus(K_WRITE,   16'hA5C3, 4, 0, 0, 0, "write");
        applyStimulus(K_READ,    16'h1234, 1, 0, 0, 0, "abort_ras");
        applyStimulus(K_WRITE,   16'h4321, 2, 0, 0, 0, "abort_mux");
        applyStimulus(K_REFRESH, 16'h007F, 2, 0, 0, 0, "refresh");
        applyStimulus(K_REFRESH, 16'h9E01, 3, 0, 0, 1, "refresh_vs_rd");
        applyStimulus(K_IGNORED, 16'h5555, 3, 0, 0, 0, "unsel_rd");
        applyStimulus(K_IGNORED, 16'h6666, 2, 0, 0, 2, "no_rdwr");
        applyStimulus(K_READ,    16'hBEEF, 3, 1, 0, 0, "b2b_first");
        applyStimulus(K_READ,    16'hBEEF, 2, 0, 1, 0, "b2b_second");
        applyStimulus(K_RESET,   16'h0F5A, R + M + 2, 0, 0, 1, "reset_in_cas");

        carry = 1'b0;
        carry_kind = K_READ;
        carry_addr = 16'h0;
        for (int n = 0; n < 300; n++) begin
            if (carry) begin
                kind = carry_kind;
                a    = carry_addr;
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2: kind = K_READ;
                    3, 4, 5: kind = K_WRITE;
                    6, 7:    kind = K_REFRESH;
                    8:       kind = K_IGNORED;
                    default: kind = K_RESET;
                endcase
                a = 16'($urandom());
            end
            variant = (kind == K_IGNORED) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 1));
            h = (kind == K_RESET) ? R + M + 2 + int'($urandom_range(0, 2)) : int'($urandom_range(1, 6));
            b2b = (kind == K_READ || kind == K_WRITE) && (n < 299) && ($urandom_range(0, 3) == 0);
            applyStimulus(kind, a, h, b2b, carry, variant, $sformatf("rand%0d", n));
            carry      = b2b;
            carry_kind = kind;
            carry_addr = a;
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_sequencer.md
# dram_sequencer

Generates the DRAM strobe sequence (RAS_n, MUX, CAS_n, WE_n) for the VG8020 main RAM from the Z80 bus cycle. It drives the `mux` select of the existing `rowcol_selector`, so the multiplexed 8-bit DRAM address is always consistent with the strobe phase. It sits between the Z80 bus interface (slot/RAM decode) and the DRAM array pins.

## Interface
Parameters:
- RAS_TO_MUX, 1: cycles RAS_n is low with row address before MUX rises (>=1)
- MUX_TO_CAS, 1: cycles MUX is high before CAS_n falls (>=1)
- PRECHARGE, 2: cycles all strobes are high after a cycle ends (>=1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all inputs are already synchronous to it
- reset  in  1  synchronous, active-high
- mreq_n  in  1  Z80 memory request
- rd_n  in  1  Z80 read
- wr_n  in  1  Z80 write
- rfsh_n  in  1  Z80 refresh
- ram_sel  in  1  RAM decoded for this address (slot/page decode)
- addr  in  16  Z80 address
- dram_addr  out  8  multiplexed DRAM address (row = addr[7:0], column = addr[15:8])
- ras_n  out  1  row strobe
- cas_n  out  1  column strobe
- we_n  out  1  write enable
- mux  out  1  0 = row, 1 = column
- busy  out  1  high in every state except IDLE

## Operation
- All strobe outputs are registered. Reset values: ras_n=1, cas_n=1, we_n=1, mux=0, busy=0, dram_addr=addr[7:0].
- FSM states: IDLE, RAS, MUX, CAS, REFRESH, PRE.
- IDLE -> RAS when mreq_n=0, ram_sel=1, rfsh_n=1 and (rd_n=0 or wr_n=0). The write flag (wr_n=0) is latched on entry.
- RAS: ras_n=0, mux=0, for RAS_TO_MUX cycles, then MUX.
- MUX: ras_n=0, mux=1. we_n=0 if the write flag is latched. Lasts MUX_TO_CAS cycles, then CAS.
- CAS: ras_n=0, cas_n=0, mux=1, we_n as in MUX. Holds while mreq_n=0. mreq_n=1 -> PRE.
- Abort: mreq_n=1 during RAS or MUX -> PRE directly; CAS_n never falls.
- PRE: all strobes high, mux=0, for PRECHARGE cycles, then IDLE. Requests arriving in PRE are not accepted; they are accepted from IDLE if still asserted.
- IDLE with mreq_n=0 and rfsh_n=0: REFRESH (see Configuration).
- rfsh_n=0 and rd_n/wr_n low at the same time: refresh takes priority.
- ram_sel=0: the cycle is ignored and the FSM stays in IDLE.
- The phase counter is 2 bits wide, sized for parameters up to 4; it reloads on every state entry.
- Reset mid-cycle forces IDLE and the reset values on the next edge, regardless of state.

## Timing
- Request present at edge E (IDLE): ras_n=0 after E.
- With default parameters:
  - mux=1 after E+1
  - cas_n=0 after E+2
  - CAS held until mreq_n=1 is sampled at edge F
  - all strobes high after F
  - busy drops after F+2
- dram_addr is combinational from mux and addr; it changes in the same cycle as mux.
- we_n falls with mux and rises with cas_n, so it never precedes RAS or outlasts CAS.

## Configuration
- DRAM_REFRESH_EN defined:
  - IDLE with mreq_n=0 and rfsh_n=0 -> REFRESH, a RAS-only refresh: ras_n=0, mux=0, cas_n=1, we_n=1, row = addr[7:0].
  - REFRESH holds while mreq_n=0, then goes to PRE.
- DRAM_REFRESH_EN undefined:
  - The REFRESH state is not built; refresh cycles leave the FSM in IDLE.
  - The rfsh_n port remains and still blocks read/write starts.

## Structure
- Shared package/include holds the state encoding constants (3-bit: IDLE=0, RAS=1, MUX=2, CAS=3, REFRESH=4, PRE=5) and the idle output values.
- One sub-module: the existing `rowcol_selector` instantiated for dram_addr, driven by the registered mux.
- The FSM and phase counter are in this module.

## Test plan
- Read, addr=16'h0F5A, rd_n=0, default parameters:
  - ras_n low 1 cycle with dram_addr=8'h5A, then mux=1 with dram_addr=8'h0F, then cas_n=0.
  - we_n stays 1 throughout.
  - After mreq_n rises, all strobes are high and busy=0 two cycles later.
- Write, wr_n=0: we_n=0 exactly while mux=1; it rises together with cas_n.
- Abort: mreq_n rises the cycle after ras_n falls -> cas_n never falls; PRE is entered and idle is reached after 2 cycles.
- Refresh, rfsh_n=0, mreq_n=0, addr=16'h007F:
  - With DRAM_REFRESH_EN: ras_n=0, cas_n=1, dram_addr=8'h7F.
  - Without DRAM_REFRESH_EN: no strobe activity.
- Back-to-back: a request held through PRE starts RAS on the first IDLE cycle and never sooner.
- Reset asserted in CAS -> next edge gives ras_n=cas_n=we_n=1, mux=0, busy=0.
